// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one external rollover counter among NUM_REQ requesters.
// Each grant programs the counter with the owner's delay and returns a one-cycle done pulse.
module delay_timer_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*NUM_CNT_BITS-1:0]   req_delay,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                done,
    output logic                              busy,
    output logic                              timer_clear,
    output logic                              timer_enable,
    output logic [NUM_CNT_BITS-1:0]           timer_rollover_val,
    input  logic                              timer_rollover_flag
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [IDX_W-1:0]          last;
    logic [IDX_W-1:0]          winner;
    logic                      any_req;
    logic                      found;
    int unsigned               rr_idx;
    logic                      owner_req;
    logic [NUM_CNT_BITS-1:0]   delay_sel;
    logic [NUM_CNT_BITS-1:0]   clamped;

    // Round-robin search starting just after the last owner.
    always_comb begin
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        rr_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (32'(last) + k) % NUM_REQ;
            if (!found && req[IDX_W'(rr_idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(rr_idx);
            end
        end
    end

    // Delays below 2 cannot be honoured by the counter, so they are raised to 2.
    assign delay_sel = req_delay[32'(winner) * NUM_CNT_BITS +: NUM_CNT_BITS];
    assign clamped   = (delay_sel < NUM_CNT_BITS'(2)) ? NUM_CNT_BITS'(2) : delay_sel;
    assign owner_req = |(req & grant);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Rollover wins over a simultaneous request drop.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = LOAD;
            LOAD:    next_state = owner_req ? COUNT : IDLE;
            COUNT: begin
                if (timer_rollover_flag) begin
                    next_state = DONE;
                end else if (!owner_req) begin
                    next_state = IDLE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter control; an abort clears the counter instead of enabling it.
    always_comb begin
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state)
            LOAD:  timer_clear = 1'b1;
            COUNT: begin
                if (!timer_rollover_flag) begin
                    if (owner_req) begin
                        timer_enable = 1'b1;
                    end else begin
                        timer_clear = 1'b1;
                    end
                end
            end
            DONE:  timer_clear = 1'b1;
            default: begin
            end
        endcase
    end

    // Registered owner, completion pulse, busy flag and latched delay.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant              <= '0;
            done               <= '0;
            busy               <= 1'b0;
            timer_rollover_val <= '0;
            last               <= IDX_W'(NUM_REQ - 1);
        end else begin
            busy <= (next_state != IDLE);
            done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant              <= NUM_REQ'(1) << winner;
                        last               <= winner;
                        timer_rollover_val <= clamped;
                    end
                end
                LOAD: begin
                    if (next_state == IDLE) grant <= '0;
                end
                COUNT: begin
                    if (next_state == DONE) begin
                        done <= grant;
                    end else if (next_state == IDLE) begin
                        grant <= '0;
                    end
                end
                DONE: grant <= '0;
                default: begin
                    grant              <= '0;
                    timer_rollover_val <= '0;
                    last               <= IDX_W'(NUM_REQ - 1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-age reference model and a behavioural counter.
module tb_delay_timer_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  req_delay;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic              timer_clear;
    logic              timer_enable;
    logic [CW-1:0]     timer_rollover_val;
    logic              timer_rollover_flag;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner and age of the current transaction (age 0 = grant cycle).
    bit m_active;
    int m_owner;
    int m_n;
    int m_age;
    int m_last;
    int m_rv;

    always #5 clk = ~clk;

    delay_timer_arbiter #(.NUM_REQ(NR), .NUM_CNT_BITS(CW)) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .req                 (req),
        .req_delay           (req_delay),
        .grant               (grant),
        .done                (done),
        .busy                (busy),
        .timer_clear         (timer_clear),
        .timer_enable        (timer_enable),
        .timer_rollover_val  (timer_rollover_val),
        .timer_rollover_flag (timer_rollover_flag)
    );

    // External flex counter with a registered rollover flag.
    assign cnt_next = timer_enable ? cnt + CW'(1) : cnt;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt                 <= '0;
            timer_rollover_flag <= 1'b0;
        end else if (timer_clear) begin
            cnt                 <= '0;
            timer_rollover_flag <= 1'b0;
        end else begin
            cnt                 <= cnt_next;
            timer_rollover_flag <= (cnt_next == timer_rollover_val);
        end
    end

    function automatic int clamp2(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_n      = 0;
        m_age    = 0;
        m_last   = NR - 1;
        m_rv     = 0;
    endtask

    task automatic model_step(input logic [NR-1:0] r, input logic [NR*CW-1:0] dl);
        int w;
        bit f;
        if (!m_active) begin
            if (r != '0) begin
                f = 1'b0;
                w = 0;
                for (int k = 1; k <= NR; k++) begin
                    int idx;
                    idx = (m_last + k) % NR;
                    if (!f && r[idx]) begin
                        f = 1'b1;
                        w = idx;
                    end
                end
                m_active = 1'b1;
                m_owner  = w;
                m_last   = w;
                m_n      = clamp2(int'(dl[w*CW +: CW]));
                m_rv     = m_n;
                m_age    = 0;
            end
        end else if (m_age == 0) begin
            if (!r[m_owner]) m_active = 1'b0;
            else m_age = 1;
        end else if (m_age <= m_n + 1) begin
            if (m_age == m_n + 1) m_age = m_age + 1;
            else if (!r[m_owner]) m_active = 1'b0;
            else m_age = m_age + 1;
        end else begin
            m_active = 1'b0;
        end
    endtask

    function automatic void model_expect(input logic [NR-1:0] r,
                                         output logic [NR-1:0] g, output logic [NR-1:0] d,
                                         output logic b, output logic c, output logic e,
                                         output logic [CW-1:0] rv);
        g  = '0;
        d  = '0;
        b  = 1'b0;
        c  = 1'b0;
        e  = 1'b0;
        rv = CW'(m_rv);
        if (m_active) begin
            g = NR'(1) << m_owner;
            b = 1'b1;
            if (m_age == 0) begin
                c = 1'b1;
            end else if (m_age <= m_n) begin
                if (!r[m_owner]) c = 1'b1;
                else e = 1'b1;
            end else if (m_age == m_n + 2) begin
                d = g;
                c = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (n_rst) model_step(req, req_delay);
        #1;
    endtask

    task automatic set_delay(input int i, input int d);
        req_delay[i*CW +: CW] = CW'(d);
    endtask

    task automatic test_reset();
        req       = '0;
        req_delay = '0;
        n_rst     = 1'b0;
        model_reset();
        tick();
        tick();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", grant); end
        n_checks++; if (done !== '0) begin n_fail++; $display("FAIL reset_done got %b exp 0000", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (timer_clear !== 1'b0) begin n_fail++; $display("FAIL reset_clear got %b exp 0", timer_clear); end
        n_checks++; if (timer_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %b exp 0", timer_enable); end
        n_checks++; if (timer_rollover_val !== '0) begin n_fail++; $display("FAIL reset_rv got %0d exp 0", timer_rollover_val); end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        int en_cnt;
        int t_done;
        logic [NR-1:0] got;
        set_delay(0, 5);
        req = 4'b0001;
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b exp 0001", grant); end
        n_checks++; if (timer_clear !== 1'b1) begin n_fail++; $display("FAIL single_load_clear got %b exp 1", timer_clear); end
        n_checks++; if (timer_rollover_val !== CW'(5)) begin n_fail++; $display("FAIL single_rv got %0d exp 5", timer_rollover_val); end
        en_cnt = 0;
        t_done = -1;
        got    = '0;
        for (int t = 1; t <= 20 && t_done < 0; t++) begin
            tick();
            if (timer_enable) en_cnt++;
            if (done != '0) begin
                t_done = t;
                got    = done;
                req    = '0;
            end
        end
        n_checks++; if (t_done != 7) begin n_fail++; $display("FAIL single_done_time got %0d exp 7", t_done); end
        n_checks++; if (got !== 4'b0001) begin n_fail++; $display("FAIL single_done_val got %b exp 0001", got); end
        n_checks++; if (en_cnt != 5) begin n_fail++; $display("FAIL single_enable_cycles got %0d exp 5", en_cnt); end
        tick();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL single_grant_after got %b exp 0000", grant); end
        n_checks++; if (done !== '0) begin n_fail++; $display("FAIL single_done_width got %b exp 0000", done); end
        tick();
    endtask

    task automatic test_contention();
        int exp_order[4] = '{1, 3, 1, 3};
        int exp_rv[4]    = '{3, 4, 3, 4};
        int order[4]     = '{-1, -1, -1, -1};
        int rv_at[4]     = '{0, 0, 0, 0};
        int nd;
        int bad_busy;
        int dbl;
        logic [NR-1:0] prev_done;
        set_delay(1, 3);
        set_delay(3, 4);
        req       = 4'b1010;
        nd        = 0;
        bad_busy  = 0;
        dbl       = 0;
        prev_done = '0;
        for (int t = 0; t < 100 && nd < 4; t++) begin
            tick();
            if (grant != '0 && !busy) bad_busy++;
            if (done != '0 && prev_done != '0) dbl++;
            if (done != '0) begin
                for (int i = 0; i < NR; i++) if (done[i]) order[nd] = i;
                rv_at[nd] = int'(timer_rollover_val);
                nd++;
                if (nd == 4) req = '0;
            end
            prev_done = done;
        end
        tick();
        if (done != '0) dbl++;
        n_checks++; if (nd != 4) begin n_fail++; $display("FAIL contend_count got %0d exp 4", nd); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL contend_order[%0d] got %0d exp %0d", i, order[i], exp_order[i]); end
            n_checks++;
            if (rv_at[i] != exp_rv[i]) begin n_fail++; $display("FAIL contend_rv[%0d] got %0d exp %0d", i, rv_at[i], exp_rv[i]); end
        end
        n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL contend_busy got %0d drops exp 0", bad_busy); end
        n_checks++; if (dbl != 0) begin n_fail++; $display("FAIL contend_done_width got %0d long pulses exp 0", dbl); end
        tick();
    endtask

    task automatic test_clamp();
        int t_done;
        for (int d = 0; d < 2; d++) begin
            set_delay(2, d);
            req = 4'b0100;
            tick();
            n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL clamp_grant d=%0d got %b exp 0100", d, grant); end
            n_checks++; if (timer_rollover_val !== CW'(2)) begin n_fail++; $display("FAIL clamp_rv d=%0d got %0d exp 2", d, timer_rollover_val); end
            t_done = -1;
            for (int t = 1; t <= 12 && t_done < 0; t++) begin
                tick();
                if (done != '0) begin t_done = t; req = '0; end
            end
            n_checks++; if (t_done != 4) begin n_fail++; $display("FAIL clamp_done_time d=%0d got %0d exp 4", d, t_done); end
            tick();
        end
    endtask

    task automatic test_abort();
        int clr_cnt;
        int bad;
        int t_done;
        set_delay(0, 9);
        req = 4'b0001;
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL abort_grant got %b exp 0001", grant); end
        tick();
        tick();
        tick();
        req = '0;
        #1;
        n_checks++; if (timer_clear !== 1'b1) begin n_fail++; $display("FAIL abort_clear got %b exp 1", timer_clear); end
        n_checks++; if (timer_enable !== 1'b0) begin n_fail++; $display("FAIL abort_enable got %b exp 0", timer_enable); end
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL abort_grant_hold got %b exp 0001", grant); end
        clr_cnt = 1;
        tick();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL abort_grant_clear got %b exp 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        bad = 0;
        for (int t = 0; t < 15; t++) begin
            if (done != '0) bad++;
            if (timer_clear) clr_cnt++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses exp 0", bad); end
        n_checks++; if (clr_cnt != 1) begin n_fail++; $display("FAIL abort_clear_count got %0d exp 1", clr_cnt); end
        set_delay(0, 3);
        req = 4'b0001;
        tick();
        t_done = -1;
        for (int t = 1; t <= 10 && t_done < 0; t++) begin
            tick();
            if (done == 4'b0001) begin t_done = t; req = '0; end
        end
        n_checks++; if (t_done != 5) begin n_fail++; $display("FAIL abort_next_done got %0d exp 5", t_done); end
        tick();
    endtask

    task automatic test_race();
        int t_flag;
        set_delay(1, 3);
        req = 4'b0010;
        tick();
        t_flag = -1;
        for (int t = 1; t <= 10 && t_flag < 0; t++) begin
            tick();
            if (timer_rollover_flag) t_flag = t;
        end
        n_checks++; if (t_flag != 4) begin n_fail++; $display("FAIL race_flag_time got %0d exp 4", t_flag); end
        req = '0;
        #1;
        n_checks++; if (timer_enable !== 1'b0) begin n_fail++; $display("FAIL race_enable got %b exp 0", timer_enable); end
        n_checks++; if (timer_clear !== 1'b0) begin n_fail++; $display("FAIL race_clear got %b exp 0", timer_clear); end
        tick();
        n_checks++; if (done !== 4'b0010) begin n_fail++; $display("FAIL race_done got %b exp 0010", done); end
        tick();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL race_grant_after got %b exp 0000", grant); end
    endtask

    task automatic test_reset_mid();
        set_delay(2, 8);
        req = 4'b0100;
        tick();
        tick();
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL rstmid_grant got %b exp 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        n_checks++; if (timer_clear !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got %b exp 0", timer_clear); end
        n_checks++; if (timer_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_enable got %b exp 0", timer_enable); end
        n_checks++; if (timer_rollover_val !== '0) begin n_fail++; $display("FAIL rstmid_rv got %0d exp 0", timer_rollover_val); end
        @(negedge clk);
        req   = 4'b1111;
        n_rst = 1'b1;
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant got %b exp 0001", grant); end
        req = '0;
        tick();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL rstmid_load_abort got %b exp 0000", grant); end
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        logic          eb;
        logic          ec;
        logic          ee;
        logic [CW-1:0] erv;
        req = '0;
        tick();
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (req[i]) begin
                    if (m_active && m_owner == i && m_age == m_n + 2) begin
                        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                    end else if (m_active && m_owner == i) begin
                        if ($urandom_range(39, 0) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(99, 0) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(5, 0) == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom_range(3, 0) == 0) req_delay[i*CW +: CW] = CW'($urandom);
            end
            #1;
            model_expect(req, eg, ed, eb, ec, ee, erv);
            n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL rnd_grant cyc %0d got %b exp %b", cyc, grant, eg); end
            n_checks++; if (done !== ed) begin n_fail++; $display("FAIL rnd_done cyc %0d got %b exp %b", cyc, done, ed); end
            n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, eb); end
            n_checks++; if (timer_clear !== ec) begin n_fail++; $display("FAIL rnd_clear cyc %0d got %b exp %b", cyc, timer_clear, ec); end
            n_checks++; if (timer_enable !== ee) begin n_fail++; $display("FAIL rnd_enable cyc %0d got %b exp %b", cyc, timer_enable, ee); end
            n_checks++; if (timer_rollover_val !== erv) begin n_fail++; $display("FAIL rnd_rv cyc %0d got %0d exp %0d", cyc, timer_rollover_val, erv); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_clamp();
        test_abort();
        test_race();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
- Shares one flex rollover counter among NUM_REQ requesters. Each requester needs a programmable cycle delay.
- The block arbitrates round-robin and configures the counter (rollover value, clear, enable). It watches the counter's rollover flag and returns a one-cycle done pulse to the owning requester.
- It sits between peripheral FSMs needing timed waits and a single externally instantiated counter of width NUM_CNT_BITS.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_CNT_BITS, 4, counter width; also the width of each requested delay.

Ports:
- clk  input  1  clock.
- n_rst  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester level request; held high until done or deliberately dropped (abort).
- req_delay  input  NUM_REQ*NUM_CNT_BITS  packed delays; slice i = bits [i*NUM_CNT_BITS +: NUM_CNT_BITS]. Sampled at grant.
- grant  output  NUM_REQ  one-hot owner, registered.
- done  output  NUM_REQ  one-cycle completion pulse to owner.
- busy  output  1  high whenever state != IDLE.
- timer_clear  output  1  drives counter clear.
- timer_enable  output  1  drives counter count_enable.
- timer_rollover_val  output  NUM_CNT_BITS  drives counter rollover_val.
- timer_rollover_flag  input  1  counter rollover flag.

Behaviour:
- Counter contract:
  - Clear forces count to 0.
  - Each enabled cycle increments the count.
  - The flag is registered; it is high in the cycle the count equals rollover_val, reached after N enabled cycles from 0 (N>=2).
- Reset values:
  - State IDLE; grant=0, done=0, busy=0.
  - timer_clear=0, timer_enable=0, timer_rollover_val=0.
  - Latched delay=0; RR pointer last=NUM_REQ-1, so index 0 has priority first.
- Delay clamp: latched delay = max(req_delay[i], 2). Values 0 and 1 become 2.
- FSM states: IDLE, LOAD, COUNT, DONE.
  - IDLE:
    - If any req is high, the winner is the first asserted index searching last+1, last+2, … modulo NUM_REQ.
    - Next edge: grant=onehot(winner), last=winner, latch the clamped delay, go to LOAD. If no req, stay.
  - LOAD:
    - timer_clear=1, timer_enable=0.
    - Next state COUNT, or IDLE on abort.
  - COUNT:
    - timer_enable = !timer_rollover_flag.
    - If the flag is high, go to DONE.
    - Else if req[owner] is low, abort: go to IDLE.
    - Else stay.
  - DONE:
    - done = grant for exactly this cycle; timer_clear=1, timer_enable=0.
    - Next edge: grant=0, go to IDLE.
- timer_rollover_val equals the latched delay from LOAD through DONE, and is stable throughout. It holds its last value in IDLE.
- timer_clear and timer_enable are never high together.
- Timing: with grant first visible in cycle G (LOAD), COUNT occupies cycles G+1..G+N+1 and the done pulse occurs in cycle G+N+2. Total from the IDLE sampling edge is N+3 cycles.
- Abort:
  - No done pulse.
  - grant clears and timer_clear=1 on the transition cycle, then IDLE.
  - The pointer still advances, so the aborter is not favoured.
- Simultaneous flag high and req[owner] low in COUNT: the flag wins, done is pulsed.
- Back-to-back requests:
  - A requester still holding req in the IDLE cycle after DONE is treated as a new request.
  - Round-robin gives other pending requesters priority over the previous owner.
- Requests arriving while busy are ignored until IDLE. req_delay changes after the grant are ignored.
- Reset mid-operation: immediate return to reset values. The counter is expected to be reset by the same n_rst.
- Unknown or illegal state encodings recover to IDLE with outputs at their reset values.

Test Plan:
- Single request: req[0]=1, req_delay[0]=5.
  - grant=0001 in the LOAD cycle; timer_enable high for 5 cycles.
  - done[0] pulses exactly 7 cycles after grant rises; grant low the cycle after.
- Contention: req=1010 with delays 3 and 4, both held, re-requested after done.
  - Grant order 1,3,1,3.
  - done[1] and done[3] each single-cycle; busy never drops between the grant and the done of any one transaction.
- Clamp: req_delay[2]=0, then 1.
  - timer_rollover_val=2 both times; done 4 cycles after grant.
- Abort: req[0] dropped in the 3rd COUNT cycle with delay 9.
  - No done pulse; grant clears next edge; timer_clear asserted once; next request is served normally.
- Race: req[owner] dropped in the same cycle timer_rollover_flag=1 → done pulse still issued.
- Reset: n_rst asserted mid-COUNT (async, between edges).
  - All outputs 0 immediately.
  - After release, req=0001 is granted first.
